// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch stage. Owns the PC, issues single-outstanding
//            word requests to instruction memory, and buffers replies in a
//            two-entry FIFO that feeds the R-type datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instru,
    output logic [31:0] instru_pc,
    output logic        instru_valid,
    input  logic        instru_ready
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_REQ     = 2'd1;
    localparam logic [1:0]  S_WAIT    = 2'd2;
    localparam logic [1:0]  S_FLUSH   = 2'd3;
    localparam logic [31:0] c_PC_STEP = 32'(PC_STEP);
    localparam logic [1:0]  c_FULL    = 2'(DEPTH);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_buf_data [0:1];
    logic [31:0] r_buf_pc   [0:1];
    logic        r_head;
    logic [1:0]  r_count;
    logic [1:0]  w_count_next;
    logic        w_valid;
    logic        w_pop;
    logic        w_push;
    logic        w_wr_idx;
    logic        w_grant;

    // The head is hidden during a redirect so nothing transfers that cycle.
    assign w_valid  = (r_count != 2'd0) && !redirect;
    assign w_pop    = w_valid && instru_ready;
    assign w_push   = (r_state == S_WAIT) && imem_rvalid && !redirect
                      && ((r_count < c_FULL) || w_pop);
    assign w_wr_idx = r_head ^ r_count[0];
    assign w_grant  = (r_state == S_REQ) && imem_gnt;

    always_comb begin
        w_count_next = r_count;
        if (redirect) begin
            w_count_next = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 2'd1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            case (r_state)
                S_IDLE:  w_state_next = S_REQ;
                S_REQ:   w_state_next = imem_gnt ? S_FLUSH : S_REQ;
                S_WAIT:  w_state_next = imem_rvalid ? S_REQ : S_FLUSH;
                S_FLUSH: w_state_next = imem_rvalid ? S_REQ : S_FLUSH;
                default: w_state_next = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = (w_count_next < c_FULL) ? S_REQ : S_IDLE;
                S_REQ:   w_state_next = imem_gnt ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_next = (w_count_next < c_FULL) ? S_REQ : S_IDLE;
                    end
                end
                S_FLUSH: w_state_next = imem_rvalid ? S_REQ : S_FLUSH;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        imem_req     = (r_state == S_REQ);
        imem_addr    = r_pc;
        instru_valid = w_valid;
        instru       = (r_count != 2'd0) ? r_buf_data[r_head] : 32'd0;
        instru_pc    = (r_count != 2'd0) ? r_buf_pc[r_head]   : 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_fetch_pc <= 32'd0;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc & ~32'd3;
            end else if (w_grant) begin
                r_pc <= r_pc + c_PC_STEP;
            end
            if (w_grant) begin
                r_fetch_pc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head        <= 1'b0;
            r_count       <= 2'd0;
            r_buf_data[0] <= 32'd0;
            r_buf_data[1] <= 32'd0;
            r_buf_pc[0]   <= 32'd0;
            r_buf_pc[1]   <= 32'd0;
        end else begin
            r_count <= w_count_next;
            if (redirect) begin
                r_head <= 1'b0;
            end else if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_push) begin
                r_buf_data[w_wr_idx] <= imem_rdata;
                r_buf_pc[w_wr_idx]   <= r_fetch_pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Scoreboard bench for instr_fetch with a one-outstanding memory
//            model that answers one cycle after each grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] instru;
    logic [31:0] instru_pc;
    logic        instru_valid;
    logic        instru_ready = 1'b0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    ent_t        m_e;
    int          n_vec = 0;
    int          n_err = 0;
    bit          gnt_on = 1'b0;
    bit          pend = 1'b0;
    bit          pend_flush = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic        s_req = 1'b0;
    logic [31:0] s_addr = 32'd0;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .instru       (instru),
        .instru_pc    (instru_pc),
        .instru_valid (instru_valid),
        .instru_ready (instru_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'h0022_1820;
    endfunction

    // Sample request and compare every transfer against the scoreboard head.
    always @(negedge clk) begin
        s_req  = imem_req;
        s_addr = imem_addr;
        if (rst && instru_valid && instru_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                $display("FAIL xfer_unexpected got pc=%h data=%h required no transfer", instru_pc, instru);
                n_err++;
            end else begin
                m_e = sb.pop_front();
                if ({instru_pc, instru} !== m_e) begin
                    $display("FAIL xfer got pc=%h data=%h required pc=%h data=%h",
                             instru_pc, instru, m_e.pc, m_e.data);
                    n_err++;
                end
            end
        end
    end

    // One clock: update the memory model from what the edge saw, then drive.
    task automatic tick();
        @(posedge clk);
        if (redirect) sb.delete();
        if (imem_rvalid) begin
            if (pend && !pend_flush && !redirect)
                sb.push_back({pend_addr, data_of(pend_addr)});
            pend = 1'b0;
        end else if (redirect && pend) begin
            pend_flush = 1'b1;
        end
        if (s_req && imem_gnt) begin
            pend       = 1'b1;
            pend_addr  = s_addr;
            pend_flush = redirect;
        end
        #1;
        imem_gnt    = gnt_on;
        imem_rvalid = pend;
        imem_rdata  = pend ? data_of(pend_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pend = 1'b0; pend_flush = 1'b0; sb.delete();
        gnt_on = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        redirect = 1'b0; instru_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = instru_valid;
        end
        n_vec++;
        if (!ok) begin
            $display("FAIL %s_timeout got no instru_valid required valid within 20 cycles", name);
            n_err++;
        end
    endtask

    task automatic drain(input string name);
        gnt_on = 1'b0; imem_gnt = 1'b0; instru_ready = 1'b1;
        repeat (6) tick();
        n_vec++;
        if (sb.size() != 0 || instru_valid !== 1'b0) begin
            $display("FAIL %s_drain got %0d pending valid=%b required 0 pending valid=0",
                     name, sb.size(), instru_valid);
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({imem_req, imem_addr, instru_valid, instru, instru_pc} !== {1'b0, 32'd0, 1'b0, 32'd0, 32'd0}) begin
            $display("FAIL reset_outputs got req=%b addr=%h v=%b i=%h pc=%h required all zero",
                     imem_req, imem_addr, instru_valid, instru, instru_pc);
            n_err++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        instru_ready = 1'b1; gnt_on = 1'b1;
        wait_valid("basic");
        n_vec++;
        if (instru !== 32'h0022_1820 || instru_pc !== 32'h0) begin
            $display("FAIL basic_head got %h@%h required 00221820@00000000", instru, instru_pc);
            n_err++;
        end
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            $display("FAIL basic_next_addr got req=%b addr=%h required req=1 addr=00000004", imem_req, imem_addr);
            n_err++;
        end
        drain("basic");
    endtask

    task automatic test_buffer();
        do_reset();
        instru_ready = 1'b0; gnt_on = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (instru_valid !== 1'b1 || instru_pc !== 32'h0 || sb.size() != 2) begin
            $display("FAIL buffer_full got v=%b pc=%h held=%0d required v=1 pc=00000000 held=2",
                     instru_valid, instru_pc, sb.size());
            n_err++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (imem_req !== 1'b0) begin
                $display("FAIL buffer_idle got req=%b required 0", imem_req);
                n_err++;
            end
        end
        instru_ready = 1'b1;
        tick();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instru_pc !== 32'h4) begin
            $display("FAIL buffer_resume got req=%b addr=%h head=%h required req=1 addr=00000008 head=00000004",
                     imem_req, imem_addr, instru_pc);
            n_err++;
        end
        drain("buffer");
    endtask

    task automatic test_redirect_wait();
        bit ok = 1'b0;
        do_reset();
        instru_ready = 1'b1; gnt_on = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = imem_req && (imem_addr == 32'h8);
        end
        n_vec++;
        if (!ok) begin
            $display("FAIL rdw_reach got addr=%h required request at 00000008", imem_addr);
            n_err++;
        end
        tick();
        imem_rvalid = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        n_vec++;
        if (instru_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            $display("FAIL rdw_flush got v=%b req=%b addr=%h required v=0 req=0 addr=00000100",
                     instru_valid, imem_req, imem_addr);
            n_err++;
        end
        tick();
        n_vec++;
        if (instru_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            $display("FAIL rdw_discard got v=%b req=%b addr=%h required v=0 req=1 addr=00000100",
                     instru_valid, imem_req, imem_addr);
            n_err++;
        end
        wait_valid("rdw");
        drain("rdw");
    endtask

    task automatic test_redirect_rvalid();
        bit ok = 1'b0;
        do_reset();
        instru_ready = 1'b0; gnt_on = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = !imem_req && instru_valid && pend;
        end
        n_vec++;
        if (!ok || imem_rvalid !== 1'b1) begin
            $display("FAIL rdr_reach got rvalid=%b required WAIT with one entry and rvalid=1", imem_rvalid);
            n_err++;
        end
        instru_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        n_vec++;
        if (instru_valid !== 1'b0) begin
            $display("FAIL rdr_forced_invalid got v=%b required 0", instru_valid);
            n_err++;
        end
        tick();
        redirect = 1'b0;
        n_vec++;
        if (instru_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            $display("FAIL rdr_after got v=%b req=%b addr=%h required v=0 req=1 addr=00000200",
                     instru_valid, imem_req, imem_addr);
            n_err++;
        end
        wait_valid("rdr");
        drain("rdr");
    endtask

    task automatic test_async_reset();
        bit ok = 1'b0;
        do_reset();
        instru_ready = 1'b1; gnt_on = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = !imem_req && pend;
        end
        #2 rst = 1'b0;
        pend = 1'b0; sb.delete(); gnt_on = 1'b0; imem_gnt = 1'b0;
        #1;
        n_vec++;
        if (!ok || {imem_req, imem_addr, instru_valid, instru, instru_pc} !== {1'b0, 32'd0, 1'b0, 32'd0, 32'd0}) begin
            $display("FAIL async_reset got req=%b addr=%h v=%b i=%h pc=%h required all zero",
                     imem_req, imem_addr, instru_valid, instru, instru_pc);
            n_err++;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
            tick();
            n_vec++;
            if (instru_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                $display("FAIL async_stale got v=%b req=%b addr=%h required v=0 req=1 addr=00000000",
                         instru_valid, imem_req, imem_addr);
                n_err++;
            end
        end
        imem_rvalid = 1'b0; gnt_on = 1'b1; imem_gnt = 1'b1;
        wait_valid("async");
        drain("async");
    endtask

    task automatic test_wrap();
        do_reset();
        instru_ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_addr got req=%b addr=%h required req=1 addr=fffffffc", imem_req, imem_addr);
            n_err++;
        end
        gnt_on = 1'b1; imem_gnt = 1'b1;
        tick();
        n_vec++;
        if (imem_addr !== 32'h0) begin
            $display("FAIL wrap_pc got addr=%h required 00000000", imem_addr);
            n_err++;
        end
        wait_valid("wrap");
        drain("wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_buffer();
        test_redirect_wait();
        test_redirect_rvalid();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
